// File: rtl/overlay_fetch_pkg.sv
// Shared types and default sizes for the overlay fetch path.
// Purpose: pixel layout (RGBA, 4 bits per channel), fetch FSM state type,
//          and default FIFO/frame sizes used by overlay_fetch.
// Ports:   none (package).
package vectrex_overlay_pkg;

  // One overlay pixel. The first field is the MSB, so a 16-bit halfword
  // casts straight to {a,b,g,r}.
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] g;
    logic [3:0] r;
  } ovl_pixel_t;

  typedef enum logic [1:0] {
    OVL_IDLE  = 2'd0,
    OVL_PRIME = 2'd1,
    OVL_RUN   = 2'd2
  } ovl_state_t;

  localparam int OVL_FIFO_WORDS  = 4;
  localparam int OVL_FRAME_WORDS = 194400;  // 540x720 pixels, two per word

endpackage

// File: rtl/overlay_fetch_if.sv
// SDRAM read channel used by the overlay fetcher.
// Purpose: groups the single-word read request/response handshake.
// Signals: mem_req   - one-cycle read request pulse (master -> slave)
//          mem_addr  - halfword address [24:1], held until the response
//          mem_data  - 32-bit read data, low halfword is the earlier pixel
//          mem_valid - one-cycle response pulse, data valid in that cycle
interface overlay_fetch_if;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_valid;

  modport master (output mem_req, output mem_addr, input mem_data, input mem_valid);
  modport slave  (input mem_req, input mem_addr, output mem_data, output mem_valid);
endinterface

// File: rtl/overlay_fetch_fifo.sv
// Small first-word-fall-through FIFO buffering fetched overlay words.
// Purpose: holds up to DEPTH words; dout always shows the oldest word.
// Ports:   clk, reset (sync, active-high)
//          push/din  - write a word (accepted when not full, or when a pop
//                      frees a slot in the same cycle)
//          pop       - discard the oldest word (ignored when empty)
//          flush     - empty the FIFO; wins over push and pop
//          dout      - oldest word (undefined content when empty)
//          full, empty, count - occupancy status
module overlay_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = store[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) store[wr_ptr] <= din;
  end

endmodule

// File: rtl/overlay_fetch.sv
// Overlay image fetcher: SDRAM words -> FIFO -> one RGBA pixel per ce_pix.
// Purpose: issues single-word reads (one outstanding at a time), buffers the
//          replies, unpacks two 16-bit pixels per word and restarts at
//          address 0 on each vsync rising edge. Flags FIFO underruns.
// Ports:   clk, reset (sync, active-high)
//          enable                - overlay usable; low forces IDLE
//          ce_pix, hblank, vblank - pixel timing; a pixel is consumed on
//                                  ce_pix outside both blanks
//          vsync                 - rising edge starts a frame
//          mem                   - SDRAM read channel (master side)
//          bg_r/g/b/a            - registered current overlay pixel
//          underrun              - sticky, cleared at frame start
module overlay_fetch
  import vectrex_overlay_pkg::*;
#(
  parameter int FIFO_WORDS  = OVL_FIFO_WORDS,
  parameter int FRAME_WORDS = OVL_FRAME_WORDS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              ce_pix,
  input  logic              hblank,
  input  logic              vblank,
  input  logic              vsync,
  overlay_fetch_if.master   mem,
  output logic [3:0]        bg_r,
  output logic [3:0]        bg_g,
  output logic [3:0]        bg_b,
  output logic [3:0]        bg_a,
  output logic              underrun
);

  localparam int WCW = $clog2(FRAME_WORDS + 1);
  localparam int CW  = $clog2(FIFO_WORDS) + 1;
  localparam logic [WCW-1:0] FRAME_LIM = WCW'(FRAME_WORDS);
  localparam logic [CW-1:0]  DEPTH     = CW'(FIFO_WORDS);

  ovl_state_t     state;
  ovl_state_t     next_state;
  logic           vsync_d;
  logic [WCW-1:0] word_cnt;
  logic [23:0]    next_addr;
  logic [23:0]    addr_q;
  logic           req_q;
  logic           outstanding;
  logic           stale;
  logic           half;
  ovl_pixel_t     pixel;

  logic           frame_start;
  logic           pixel_slot;
  logic           go_idle;
  logic           restart;
  logic           issue;
  logic           accept;
  logic           consume;

  logic [31:0]    fifo_data;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           fifo_pop;

  assign frame_start = vsync & ~vsync_d;
  assign pixel_slot  = ce_pix & ~hblank & ~vblank;
  // The second half of a word retires it from the FIFO.
  assign fifo_pop    = consume & ~fifo_empty & half;

  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;

  assign bg_r = pixel.r;
  assign bg_g = pixel.g;
  assign bg_b = pixel.b;
  assign bg_a = pixel.a;

  overlay_fifo #(
    .DEPTH (FIFO_WORDS),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (fifo_pop),
    .flush (go_idle | restart),
    .din   (mem.mem_data),
    .dout  (fifo_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= OVL_IDLE;
    else       state <= next_state;
  end

  // enable low beats a frame start; a frame start beats normal fetching.
  always_comb begin
    next_state = state;
    go_idle    = 1'b0;
    restart    = 1'b0;
    issue      = 1'b0;
    accept     = 1'b0;
    consume    = 1'b0;
    if (!enable) begin
      next_state = OVL_IDLE;
      go_idle    = 1'b1;
    end else if (frame_start) begin
      next_state = OVL_PRIME;
      restart    = 1'b1;
    end else begin
      case (state)
        OVL_IDLE: next_state = OVL_IDLE;
        OVL_PRIME, OVL_RUN: begin
          issue   = ~outstanding & (fifo_count < DEPTH) & (word_cnt < FRAME_LIM);
          accept  = mem.mem_valid & outstanding & ~stale;
          consume = pixel_slot;
          if (state == OVL_PRIME &&
              (fifo_full || (word_cnt == FRAME_LIM && !outstanding)))
            next_state = OVL_RUN;
        end
        default: next_state = OVL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_d     <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      next_addr   <= '0;
      word_cnt    <= '0;
      outstanding <= 1'b0;
      stale       <= 1'b0;
      half        <= 1'b0;
      pixel       <= '0;
      underrun    <= 1'b0;
    end else begin
      vsync_d <= vsync;
      req_q   <= issue;
      if (go_idle) begin
        addr_q      <= '0;
        next_addr   <= '0;
        word_cnt    <= '0;
        outstanding <= 1'b0;
        stale       <= 1'b0;
        half        <= 1'b0;
        pixel       <= '0;
        underrun    <= 1'b0;
      end else if (restart) begin
        next_addr <= '0;
        word_cnt  <= '0;
        half      <= 1'b0;
        underrun  <= 1'b0;
        // A read still in flight belongs to the old frame; its reply
        // must be dropped. A reply arriving right now is dropped too.
        stale       <= outstanding & ~mem.mem_valid;
        outstanding <= outstanding & ~mem.mem_valid;
      end else begin
        if (issue) begin
          outstanding <= 1'b1;
          addr_q      <= next_addr;
          next_addr   <= next_addr + 24'd2;
          word_cnt    <= word_cnt + WCW'(1);
        end else if (mem.mem_valid && outstanding) begin
          outstanding <= 1'b0;
          stale       <= 1'b0;
        end
        if (consume) begin
          if (!fifo_empty) begin
            pixel <= half ? ovl_pixel_t'(fifo_data[31:16]) : ovl_pixel_t'(fifo_data[15:0]);
            half  <= ~half;
          end else begin
            // Half pointer stays put: alignment recovers only at frame start.
            pixel    <= '0;
            underrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_overlay_fetch.sv
// Self-checking bench for overlay_fetch with a small frame (8 words).
module tb_overlay_fetch;

  localparam int FW   = 8;
  localparam int FIFO = 4;

  logic clk;
  logic rst, en, ce, hb, vb, vs;
  logic [3:0] bg_r, bg_g, bg_b, bg_a;
  logic underrun;
  logic [15:0] dut_pix;

  overlay_fetch_if bus();

  overlay_fetch #(.FIFO_WORDS(FIFO), .FRAME_WORDS(FW)) dut (
    .clk      (clk),
    .reset    (rst),
    .enable   (en),
    .ce_pix   (ce),
    .hblank   (hb),
    .vblank   (vb),
    .vsync    (vs),
    .mem      (bus),
    .bg_r     (bg_r),
    .bg_g     (bg_g),
    .bg_b     (bg_b),
    .bg_a     (bg_a),
    .underrun (underrun)
  );

  assign dut_pix = {bg_a, bg_b, bg_g, bg_r};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int req_count = 0;

  logic [31:0] words [8];

  typedef struct {
    int          due;
    logic [23:0] addr;
  } mreq_t;
  mreq_t mq[$];
  int    lat = 3;
  bit    mem_auto = 1'b0;
  logic        mv_man = 1'b0;
  logic [31:0] md_man = 32'h0;

  // Reference model: the FIFO is a queue of pending pixels (halfwords).
  logic [15:0] m_q[$];
  bit          m_active, m_out, m_stale, m_req, m_prev_vs, m_ur;
  int          m_next;
  logic [23:0] m_addr;
  logic [15:0] m_pix;

  task automatic model_step(input logic r, e, c, h, v, s, mv, input logic [31:0] md);
    bit push_it;
    logic [31:0] pw;
    int words_held;
    bit iss;
    push_it = 1'b0;
    pw = 32'h0;
    if (r || !e) begin
      m_active = 1'b0; m_q.delete(); m_next = 0; m_out = 1'b0; m_stale = 1'b0;
      m_req = 1'b0; m_addr = 24'h0; m_pix = 16'h0; m_ur = 1'b0;
    end else if (s && !m_prev_vs) begin
      m_active = 1'b1; m_q.delete(); m_next = 0; m_ur = 1'b0; m_req = 1'b0;
      if (m_out && !mv) m_stale = 1'b1;
      else begin m_out = 1'b0; m_stale = 1'b0; end
    end else if (!m_active) begin
      m_req = 1'b0;
    end else begin
      words_held = (m_q.size() + 1) / 2;
      iss = !m_out && (words_held < FIFO) && (m_next < FW);
      m_req = iss;
      if (iss) begin
        m_addr = 24'(2 * m_next);
        m_next++;
        m_out = 1'b1;
      end else if (mv && m_out) begin
        if (!m_stale) begin push_it = 1'b1; pw = md; end
        m_out = 1'b0;
        m_stale = 1'b0;
      end
      if (c && !h && !v) begin
        if (m_q.size() > 0) m_pix = m_q.pop_front();
        else begin m_pix = 16'h0; m_ur = 1'b1; end
      end
      if (push_it) begin
        m_q.push_back(pw[15:0]);
        m_q.push_back(pw[31:16]);
      end
    end
    m_prev_vs = r ? 1'b0 : s;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // One clock: drive inputs, clock, then compare against the model.
  task automatic apply_stimulus(input logic r, e, c, h, v, s);
    rst = r; en = e; ce = c; hb = h; vb = v; vs = s;
    if (mem_auto) begin
      bus.mem_valid = 1'b0;
      bus.mem_data  = 32'h0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        bus.mem_valid = 1'b1;
        bus.mem_data  = words[mq[0].addr[3:1]];
        void'(mq.pop_front());
      end
    end else begin
      bus.mem_valid = mv_man;
      bus.mem_data  = md_man;
    end
    @(posedge clk);
    #1;
    model_step(r, e, c, h, v, s, bus.mem_valid, bus.mem_data);
    check_output("req", 32'(bus.mem_req), 32'(m_req));
    if (m_req) check_output("addr", 32'(bus.mem_addr), 32'(m_addr));
    check_output("pix", 32'(dut_pix), 32'(m_pix));
    check_output("underrun", 32'(underrun), 32'(m_ur));
    if (bus.mem_req) begin
      req_count++;
      if (mem_auto) mq.push_back('{cyc + lat, bus.mem_addr});
    end
    cyc++;
  endtask

  typedef struct {
    logic [6:0]  in_bits;   // {reset, enable, ce, hblank, vblank, vsync, mem_valid}
    logic [31:0] md;
    logic        xr;
    logic [23:0] xa;
    logic [15:0] xp;
    logic        xu;
  } vec_t;

  function automatic vec_t mk(input logic [6:0] ib, input logic [31:0] md,
                              input logic xr, input logic [23:0] xa,
                              input logic [15:0] xp, input logic xu);
    vec_t t;
    t.in_bits = ib; t.md = md; t.xr = xr; t.xa = xa; t.xp = xp; t.xu = xu;
    return t;
  endfunction

  task automatic run_frame(input int lat_i, input int lines, input bit rnd_ce,
                           input int drop_at, input int rst_at);
    int k;
    logic c, e, r;
    lat = lat_i;
    req_count = 0;
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 64; i++) apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    if (lat_i <= 3) check_output("prime_reqs", 32'(req_count), 32'(FIFO));
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < 30; p++) begin
        k = l * 30 + p;
        c = rnd_ce ? 1'($urandom_range(0, 1)) : ((p % 2) == 0);
        e = !(drop_at >= 0 && k >= drop_at && k < drop_at + 5);
        r = (k == rst_at);
        apply_stimulus(r, e, c, (p >= 24), 1'b0, 1'b0);
        if (k == drop_at || k == rst_at) begin
          check_output("idle_req", 32'(bus.mem_req), 32'h0);
          check_output("idle_pix", 32'(dut_pix), 32'h0);
          check_output("idle_ur", 32'(underrun), 32'h0);
        end
      end
    end
    if (lat_i <= 3 && drop_at < 0 && rst_at < 0)
      check_output("frame_reqs", 32'(req_count), 32'(FW));
    if (lat_i >= 40) check_output("ur_sticky", 32'(underrun), 32'h1);
  endtask

  vec_t tbl[21];

  initial begin
    rst = 1'b1; en = 1'b0; ce = 1'b0; hb = 1'b0; vb = 1'b1; vs = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_data  = 32'h0;
    words[0] = 32'h8765_4321;
    for (int i = 1; i < 8; i++) words[i] = $urandom;

    tbl[0]  = mk(7'b1000100, 32'h0, 1'b0, 24'h0, 16'h0, 1'b0);
    tbl[1]  = mk(7'b0000110, 32'h0, 1'b0, 24'h0, 16'h0, 1'b0);
    tbl[2]  = mk(7'b0100110, 32'h0, 1'b0, 24'h0, 16'h0, 1'b0);
    tbl[3]  = mk(7'b0100100, 32'h0, 1'b0, 24'h0, 16'h0, 1'b0);
    tbl[4]  = mk(7'b0100110, 32'h0, 1'b0, 24'h0, 16'h0, 1'b0);
    tbl[5]  = mk(7'b0100110, 32'h0, 1'b1, 24'h0, 16'h0, 1'b0);
    tbl[6]  = mk(7'b0100110, 32'h0, 1'b0, 24'h0, 16'h0, 1'b0);
    tbl[7]  = mk(7'b0110010, 32'h0, 1'b0, 24'h0, 16'h0, 1'b1);
    tbl[8]  = mk(7'b0100100, 32'h0, 1'b0, 24'h0, 16'h0, 1'b1);
    tbl[9]  = mk(7'b0100110, 32'h0, 1'b0, 24'h0, 16'h0, 1'b0);
    tbl[10] = mk(7'b0100111, 32'hDEAD_BEEF, 1'b0, 24'h0, 16'h0, 1'b0);
    tbl[11] = mk(7'b0100110, 32'h0, 1'b1, 24'h0, 16'h0, 1'b0);
    tbl[12] = mk(7'b0100111, 32'h8765_4321, 1'b0, 24'h0, 16'h0, 1'b0);
    tbl[13] = mk(7'b0110010, 32'h0, 1'b1, 24'h2, 16'h4321, 1'b0);
    tbl[14] = mk(7'b0110010, 32'h0, 1'b0, 24'h0, 16'h8765, 1'b0);
    tbl[15] = mk(7'b0110010, 32'h0, 1'b0, 24'h0, 16'h0, 1'b1);
    tbl[16] = mk(7'b0000110, 32'h0, 1'b0, 24'h0, 16'h0, 1'b0);
    tbl[17] = mk(7'b0000111, 32'h1234_5678, 1'b0, 24'h0, 16'h0, 1'b0);
    tbl[18] = mk(7'b0100100, 32'h0, 1'b0, 24'h0, 16'h0, 1'b0);
    tbl[19] = mk(7'b0100110, 32'h0, 1'b0, 24'h0, 16'h0, 1'b0);
    tbl[20] = mk(7'b0100110, 32'h0, 1'b1, 24'h0, 16'h0, 1'b0);

    mem_auto = 1'b0;
    for (int i = 0; i < 21; i++) begin
      mv_man = tbl[i].in_bits[0];
      md_man = tbl[i].md;
      apply_stimulus(tbl[i].in_bits[6], tbl[i].in_bits[5], tbl[i].in_bits[4],
                     tbl[i].in_bits[3], tbl[i].in_bits[2], tbl[i].in_bits[1]);
      check_output("tbl_req", 32'(bus.mem_req), 32'(tbl[i].xr));
      if (tbl[i].xr) check_output("tbl_addr", 32'(bus.mem_addr), 32'(tbl[i].xa));
      check_output("tbl_pix", 32'(dut_pix), 32'(tbl[i].xp));
      check_output("tbl_ur", 32'(underrun), 32'(tbl[i].xu));
    end

    // The table leaves a read outstanding that nobody answers; start clean.
    mv_man = 1'b0;
    mem_auto = 1'b1;
    for (int i = 0; i < 2; i++) apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    run_frame(3, 4, 1'b0, -1, -1);
    run_frame(1, 4, 1'b1, -1, -1);
    run_frame(40, 4, 1'b0, -1, -1);
    run_frame(2, 4, 1'b1, -1, -1);
    for (int f = 0; f < 6; f++)
      run_frame(int'($urandom_range(1, 6)), 3, 1'b1,
                (f % 2 == 1) ? int'($urandom_range(5, 60)) : -1, -1);
    run_frame(2, 4, 1'b0, -1, 70);
    run_frame(2, 4, 1'b1, -1, -1);
    run_frame(3, 4, 1'b0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
